// File: rtl/spi_mem_arbiter_if.sv
// Bus bundle between the three requesters, the arbiter and the QSPI memory controller.
interface spi_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 26
);
  localparam int unsigned N_REQ  = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned LOC_W  = ADDR_W - 2;

  // requester side
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ*STRB_W-1:0] req_wstrb;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       req_rdata;
  logic                    req_err;

  // memory controller side
  logic                    mem_valid;
  logic [LOC_W-1:0]        mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [STRB_W-1:0]       mem_wstrb;
  logic [2:0]              mem_ce_sel;
  logic                    mem_ready;
  logic [DATA_W-1:0]       mem_rdata;

  // environment view: drives requests and the controller responses
  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
    input  req_ready, req_rdata, req_err,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_ce_sel
  );

  // arbiter view
  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata,
    output req_ready, req_rdata, req_err,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_ce_sel
  );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter of three requesters onto one QSPI memory controller,
// with target decode (flash / PSRAM0 / PSRAM1 / unmapped) from the top address bits.
module spi_mem_arbiter #(
  parameter int unsigned ADDR_W = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  spi_mem_arbiter_if.slave        bus
);
  localparam int unsigned N_REQ  = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned LOC_W  = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE, ERR} state_t;

  state_t              state_q, state_d;
  logic [1:0]          rr_q, rr_d;
  logic [1:0]          idx_q, idx_d;
  logic                mem_valid_q, mem_valid_d;
  logic [2:0]          ce_q, ce_d;
  logic [LOC_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [N_REQ-1:0]    ready_q, ready_d;
  logic                err_q, err_d;

  logic                found;
  logic [1:0]          gnt;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [STRB_W-1:0]   sel_wstrb;
  logic [1:0]          sel_tgt;

  // Round-robin search starting at rr_q, ascending modulo 3.
  always_comb begin
    found = 1'b0;
    gnt   = rr_q;
    for (int k = 0; k < 3; k++) begin
      logic [1:0] cand;
      int unsigned c;
      c    = (32'(rr_q) + 32'(k)) % 3;
      cand = 2'(c);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  // Payload mux for the requester under grant.
  always_comb begin
    case (gnt)
      2'd0: begin
        sel_addr  = bus.req_addr[0*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[0*DATA_W +: DATA_W];
        sel_wstrb = bus.req_wstrb[0*STRB_W +: STRB_W];
      end
      2'd1: begin
        sel_addr  = bus.req_addr[1*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[1*DATA_W +: DATA_W];
        sel_wstrb = bus.req_wstrb[1*STRB_W +: STRB_W];
      end
      default: begin
        sel_addr  = bus.req_addr[2*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[2*DATA_W +: DATA_W];
        sel_wstrb = bus.req_wstrb[2*STRB_W +: STRB_W];
      end
    endcase
    sel_tgt = sel_addr[ADDR_W-1 -: 2];
  end

  // Next-state and next-output logic; completion pulses default low.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    idx_d       = idx_q;
    mem_valid_d = mem_valid_q;
    ce_d        = ce_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    ready_d     = '0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d   = gnt;
          rr_d    = (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
          addr_d  = sel_addr[LOC_W-1:0];
          wdata_d = sel_wdata;
          wstrb_d = sel_wstrb;
          if (sel_tgt == 2'b11) begin
            // unmapped target: answer locally, never touch the controller
            state_d = ERR;
            ready_d = 3'b001 << gnt;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d     = ISSUE;
            mem_valid_d = 1'b1;
            ce_d        = 3'b001 << sel_tgt;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_ready) begin
          state_d     = DONE;
          mem_valid_d = 1'b0;
          ce_d        = '0;
          rdata_d     = bus.mem_rdata;
          ready_d     = 3'b001 << idx_q;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 2'd0;
      idx_q       <= 2'd0;
      mem_valid_q <= 1'b0;
      ce_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      ready_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      mem_valid_q <= mem_valid_d;
      ce_q        <= ce_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_ce_sel = ce_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wstrb  = wstrb_q;
  assign bus.req_ready  = ready_q;
  assign bus.req_rdata  = rdata_q;
  assign bus.req_err    = err_q;
endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter: contention, single read, spurious ready,
// unmapped access, stalled PSRAM1 write and reset during ISSUE.
module tb_spi_mem_arbiter;
  localparam int unsigned ADDR_W = 26;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  spi_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  spi_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [25:0] a, input logic [31:0] wd,
                         input logic [3:0] ws);
    bus.req_addr[idx*26 +: 26] = a;
    bus.req_wdata[idx*32 +: 32] = wd;
    bus.req_wstrb[idx*4 +: 4] = ws;
  endtask

  logic [2:0]  exp_ce   [3];
  logic [23:0] exp_addr [3];
  logic [2:0]  onehot;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    tick();
    tick();

    // reset state
    chk("rst_mem_valid", 64'(bus.mem_valid), 64'h0);
    chk("rst_ce_sel",    64'(bus.mem_ce_sel), 64'h0);
    chk("rst_mem_addr",  64'(bus.mem_addr), 64'h0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_req_err",   64'(bus.req_err), 64'h0);
    chk("rst_req_rdata", 64'(bus.req_rdata), 64'h0);
    rst = 1'b0;
    tick();

    // contention: all three valid, controller answers immediately
    set_req(0, 26'h0000010, 32'h0, 4'h0);
    set_req(1, 26'h1000020, 32'h0, 4'h0);
    set_req(2, 26'h2000030, 32'h0, 4'h0);
    exp_ce[0] = 3'b001; exp_addr[0] = 24'h000010;
    exp_ce[1] = 3'b010; exp_addr[1] = 24'h000020;
    exp_ce[2] = 3'b100; exp_addr[2] = 24'h000030;
    bus.mem_rdata = 32'hA5A50000;
    bus.mem_ready = 1'b1;
    bus.req_valid = 3'b111;
    for (int t = 0; t < 6; t++) begin
      onehot = 3'b001 << (t % 3);
      tick();
      chk("cont_issue_valid", 64'(bus.mem_valid), 64'h1);
      chk("cont_issue_ce",    64'(bus.mem_ce_sel), 64'(exp_ce[t % 3]));
      chk("cont_issue_addr",  64'(bus.mem_addr), 64'(exp_addr[t % 3]));
      chk("cont_issue_noready", 64'(bus.req_ready), 64'h0);
      tick();
      chk("cont_done_ready", 64'(bus.req_ready), 64'(onehot));
      chk("cont_done_rdata", 64'(bus.req_rdata), 64'hA5A50000);
      chk("cont_done_ce",    64'(bus.mem_ce_sel), 64'h0);
      tick();
      if (t == 5) begin
        bus.req_valid = '0;
        bus.mem_ready = 1'b0;
      end
      chk("cont_idle_noready", 64'(bus.req_ready), 64'h0);
    end

    // single read from flash, mem_ready one cycle after mem_valid
    set_req(0, 26'h0000100, 32'h0, 4'h0);
    bus.req_valid = 3'b001;
    tick();
    chk("rd_valid",  64'(bus.mem_valid), 64'h1);
    chk("rd_ce",     64'(bus.mem_ce_sel), 64'h1);
    chk("rd_addr",   64'(bus.mem_addr), 64'h000100);
    chk("rd_wstrb",  64'(bus.mem_wstrb), 64'h0);
    tick();
    chk("rd_stall_valid", 64'(bus.mem_valid), 64'h1);
    chk("rd_stall_noready", 64'(bus.req_ready), 64'h0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    chk("rd_ready", 64'(bus.req_ready), 64'h1);
    chk("rd_rdata", 64'(bus.req_rdata), 64'hCAFEF00D);
    chk("rd_err",   64'(bus.req_err), 64'h0);
    chk("rd_done_valid", 64'(bus.mem_valid), 64'h0);
    bus.req_valid = '0;
    tick();
    chk("rd_idle_noready", 64'(bus.req_ready), 64'h0);

    // spurious mem_ready while idle
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    tick();
    chk("spur_noready", 64'(bus.req_ready), 64'h0);
    chk("spur_novalid", 64'(bus.mem_valid), 64'h0);
    bus.mem_ready = 1'b0;
    tick();
    chk("spur_noready2", 64'(bus.req_ready), 64'h0);
    chk("spur_rdata_kept", 64'(bus.req_rdata), 64'hCAFEF00D);

    // unmapped access from requester 2
    set_req(2, 26'h3000000, 32'h0, 4'h0);
    bus.req_valid = 3'b100;
    tick();
    chk("err_novalid", 64'(bus.mem_valid), 64'h0);
    chk("err_ce",      64'(bus.mem_ce_sel), 64'h0);
    chk("err_ready",   64'(bus.req_ready), 64'h4);
    chk("err_flag",    64'(bus.req_err), 64'h1);
    chk("err_rdata",   64'(bus.req_rdata), 64'h0);
    bus.req_valid = '0;
    tick();
    chk("err_idle_ready", 64'(bus.req_ready), 64'h0);
    chk("err_idle_flag",  64'(bus.req_err), 64'h0);
    chk("err_idle_valid", 64'(bus.mem_valid), 64'h0);

    // PSRAM1 write from requester 1 with a 10-cycle stall
    set_req(1, 26'h2000040, 32'h12345678, 4'b0011);
    bus.req_valid = 3'b010;
    tick();
    chk("wr_valid", 64'(bus.mem_valid), 64'h1);
    chk("wr_ce",    64'(bus.mem_ce_sel), 64'h4);
    chk("wr_addr",  64'(bus.mem_addr), 64'h000040);
    chk("wr_wdata", 64'(bus.mem_wdata), 64'h12345678);
    chk("wr_wstrb", 64'(bus.mem_wstrb), 64'h3);
    // valid dropped and payload changed mid-transaction must not disturb it
    bus.req_valid = '0;
    set_req(1, 26'h0000000, 32'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("wr_stall_valid", 64'(bus.mem_valid), 64'h1);
      chk("wr_stall_payload",
          64'({bus.mem_ce_sel, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata}),
          64'({3'b100, 24'h000040, 4'b0011, 32'h12345678}));
      chk("wr_stall_noready", 64'(bus.req_ready), 64'h0);
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("wr_ready", 64'(bus.req_ready), 64'h2);
    chk("wr_err",   64'(bus.req_err), 64'h0);
    tick();
    chk("wr_idle_ready", 64'(bus.req_ready), 64'h0);

    // reset during ISSUE; rr pointer now sits at 2
    set_req(1, 26'h1000080, 32'h0, 4'h0);
    bus.req_valid = 3'b010;
    tick();
    chk("rs_issue_valid", 64'(bus.mem_valid), 64'h1);
    chk("rs_issue_ce",    64'(bus.mem_ce_sel), 64'h2);
    tick();
    rst = 1'b1;
    #1;
    chk("rs_async_valid", 64'(bus.mem_valid), 64'h0);
    chk("rs_async_ce",    64'(bus.mem_ce_sel), 64'h0);
    chk("rs_async_addr",  64'(bus.mem_addr), 64'h0);
    set_req(2, 26'h0000200, 32'h0, 4'h0);
    bus.req_valid = 3'b110;
    tick();
    chk("rs_hold_ready", 64'(bus.req_ready), 64'h0);
    rst = 1'b0;
    tick();
    chk("rs_grant_valid", 64'(bus.mem_valid), 64'h1);
    chk("rs_grant_ce",    64'(bus.mem_ce_sel), 64'h2);
    chk("rs_grant_addr",  64'(bus.mem_addr), 64'h000080);
    chk("rs_grant_noready", 64'(bus.req_ready), 64'h0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0BADF00D;
    tick();
    bus.mem_ready = 1'b0;
    bus.req_valid = '0;
    chk("rs_ready", 64'(bus.req_ready), 64'h2);
    chk("rs_rdata", 64'(bus.req_rdata), 64'h0BADF00D);
    tick();
    chk("rs_idle_ready", 64'(bus.req_ready), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
